// File: rtl/dual_core_mem_arbiter.sv
// Two-core RAM port arbiter: round-robin between cores, data before instruction
// within a core, single outstanding RAM transaction, and LL/SC reservation tracking.
module dual_core_mem_arbiter #(
    parameter int WORD_W = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [1:0]             iREN,
    input  logic [1:0][WORD_W-1:0] iaddr,
    output logic [1:0]             iwait,
    output logic [1:0][WORD_W-1:0] iload,
    input  logic [1:0]             dREN,
    input  logic [1:0]             dWEN,
    input  logic [1:0]             datomic,
    input  logic [1:0][WORD_W-1:0] daddr,
    input  logic [1:0][WORD_W-1:0] dstore,
    output logic [1:0]             dwait,
    output logic [1:0][WORD_W-1:0] dload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic [1:0]             ramstate,
    output logic [1:0]             link_valid
);

    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, SERVE, SCFAIL} state_t;

    state_t                   state;
    logic                     last_core;
    logic                     g_core;
    logic                     g_data;
    logic                     g_atomic;
    logic [1:0][WORD_W-3:0]   linkaddr;

    logic sel_valid, sel_core, sel_data, sel_first;
    logic sc_sel, sc_ok, ram_end, done, scf;

    // Candidate pick: the core not granted last goes first, D beats I inside a core.
    always_comb begin
        sel_first = ~last_core;
        sel_valid = 1'b0;
        sel_core  = sel_first;
        sel_data  = 1'b0;
        if (dREN[sel_first] | dWEN[sel_first] | iREN[sel_first]) begin
            sel_valid = 1'b1;
            sel_core  = sel_first;
            sel_data  = dREN[sel_first] | dWEN[sel_first];
        end else if (dREN[~sel_first] | dWEN[~sel_first] | iREN[~sel_first]) begin
            sel_valid = 1'b1;
            sel_core  = ~sel_first;
            sel_data  = dREN[~sel_first] | dWEN[~sel_first];
        end
        sc_sel = sel_data & dWEN[sel_core] & datomic[sel_core];
        sc_ok  = link_valid[sel_core] &&
                 (linkaddr[sel_core] == daddr[sel_core][WORD_W-1:2]);
    end

    assign ram_end = (ramstate == ACCESS) || (ramstate == ERROR);
    // Reset suppresses any completion of an abandoned transaction.
    assign done    = !RST && (state == SERVE) && ram_end;
    assign scf     = !RST && (state == SCFAIL);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            last_core  <= 1'b1;
            g_core     <= 1'b0;
            g_data     <= 1'b0;
            g_atomic   <= 1'b0;
            ramREN     <= 1'b0;
            ramWEN     <= 1'b0;
            ramaddr    <= '0;
            ramstore   <= '0;
            link_valid <= 2'b00;
            linkaddr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        g_core   <= sel_core;
                        g_data   <= sel_data;
                        g_atomic <= sel_data & datomic[sel_core];
                        if (sc_sel && !sc_ok) begin
                            state <= SCFAIL;
                        end else begin
                            state    <= SERVE;
                            ramREN   <= sel_data ? dREN[sel_core] : 1'b1;
                            ramWEN   <= sel_data & dWEN[sel_core];
                            ramaddr  <= sel_data ? daddr[sel_core] : iaddr[sel_core];
                            ramstore <= sel_data ? dstore[sel_core] : '0;
                        end
                    end
                end
                SERVE: begin
                    if (ram_end) begin
                        state     <= IDLE;
                        last_core <= g_core;
                        ramREN    <= 1'b0;
                        ramWEN    <= 1'b0;
                        ramaddr   <= '0;
                        ramstore  <= '0;
                        if (ramREN && g_atomic) begin
                            link_valid[g_core] <= 1'b1;
                            linkaddr[g_core]   <= ramaddr[WORD_W-1:2];
                        end
                        // Any write to a reserved word kills that reservation, writer included.
                        if (ramWEN) begin
                            for (int c = 0; c < 2; c++)
                                if (linkaddr[c] == ramaddr[WORD_W-1:2])
                                    link_valid[c] <= 1'b0;
                        end
                    end
                end
                SCFAIL: begin
                    link_valid[g_core] <= 1'b0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            logic i_cmp, d_cmp;
            i_cmp    = done && (g_core == 1'(c)) && !g_data;
            d_cmp    = (done || scf) && (g_core == 1'(c)) && g_data;
            iwait[c] = iREN[c] & ~i_cmp;
            iload[c] = i_cmp ? ramload : '0;
            dwait[c] = (dREN[c] | dWEN[c]) & ~d_cmp;
            dload[c] = '0;
            if (d_cmp && done)
                dload[c] = ramWEN ? (g_atomic ? WORD_W'(1) : '0) : ramload;
        end
    end

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// Scoreboard bench for dual_core_mem_arbiter: a small RAM model answers strobes,
// expected completions are queued at drive time and popped when a wait drops.
module tb_dual_core_mem_arbiter;

    localparam int W = 32;
    localparam logic [31:0] KEY = 32'h5A5A_0000;
    localparam int K_I = 0, K_LD = 1, K_SW = 2, K_LL = 3, K_SC = 4;

    logic              CLK = 0, RST = 1;
    logic [1:0]        iREN = '0, dREN = '0, dWEN = '0, datomic = '0;
    logic [1:0][W-1:0] iaddr = '0, daddr = '0, dstore = '0;
    logic [1:0]        iwait, dwait, link_valid;
    logic [1:0][W-1:0] iload, dload;
    logic              ramREN, ramWEN;
    logic [W-1:0]      ramaddr, ramstore, ramload;
    logic [1:0]        ramstate;

    int busy = 0, cnt = 0, cyc = 0, wen_cycles = 0;
    logic err = 0, ovr_en = 0;
    logic [31:0] ovr = '0, last_wr = '0;
    int n_chk = 0, n_pass = 0;

    typedef struct { logic [1:0] id; logic [31:0] val; int cyc; } exp_t;
    exp_t sbq[$];

    dual_core_mem_arbiter #(.WORD_W(W)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .link_valid(link_valid)
    );

    always #5 CLK = ~CLK;

    // RAM model: BUSY for `busy` cycles of a strobe, then ACCESS (or ERROR).
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        cnt <= (ramREN | ramWEN) ? cnt + 1 : 0;
    end

    always_comb begin
        ramstate = 2'd0;
        if (ramREN | ramWEN) ramstate = (cnt >= busy) ? (err ? 2'd3 : 2'd2) : 2'd1;
        ramload = ovr_en ? ovr : (ramaddr ^ KEY);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic got_cmpl(input int c, input int port, input logic [31:0] v);
        exp_t e;
        if (sbq.size() == 0) begin
            chk("unexp_cmpl", 32'(sbq.size()), 32'd1);
            return;
        end
        e = sbq.pop_front();
        chk("cmpl_id", {30'd0, c[0], port[0]}, {30'd0, e.id});
        chk("cmpl_data", v, e.val);
        if (e.cyc >= 0) chk("cmpl_cycle", 32'(cyc), 32'(e.cyc));
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (ramWEN) wen_cycles++;
            if (ramWEN && ramstate[1]) last_wr = ramstore;
            for (int c = 0; c < 2; c++) begin
                if (iREN[c] && !iwait[c]) got_cmpl(c, 0, iload[c]);
                if ((dREN[c] | dWEN[c]) && !dwait[c]) got_cmpl(c, 1, dload[c]);
            end
        end
    end

    task automatic push(input int c, input int port, input logic [31:0] v, input int ecyc);
        exp_t e;
        e.id = {c[0], port[0]}; e.val = v; e.cyc = ecyc;
        sbq.push_back(e);
    endtask

    task automatic wait_empty(input int maxc);
        int k = 0;
        while (sbq.size() != 0 && k < maxc) begin
            @(negedge CLK); #1;
            k++;
        end
        if (sbq.size() != 0) begin
            chk("timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    // Called just after a rising edge; holds the request until it completes.
    task automatic req(input int c, input int kind, input logic [31:0] a,
                       input logic [31:0] st, input logic [31:0] ev, input int lat);
        case (kind)
            K_I:  begin iREN[c] = 1; iaddr[c] = a; end
            K_LD: begin dREN[c] = 1; daddr[c] = a; end
            K_SW: begin dWEN[c] = 1; daddr[c] = a; dstore[c] = st; end
            K_LL: begin dREN[c] = 1; datomic[c] = 1; daddr[c] = a; end
            default: begin dWEN[c] = 1; datomic[c] = 1; daddr[c] = a; dstore[c] = st; end
        endcase
        push(c, (kind == K_I) ? 0 : 1, ev, (lat < 0) ? -1 : cyc + lat);
        wait_empty(60);
        @(posedge CLK); #1;
        iREN[c] = 0; dREN[c] = 0; dWEN[c] = 0; datomic[c] = 0;
    endtask

    initial begin
        int n, w0;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, w0;
        // Both cores ask for data straight out of reset.
        dREN = 2'b11; daddr[0] = 32'h0000_0040; daddr[1] = 32'h0000_0080;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_link", {30'd0, link_valid}, 32'd0);
        chk("rst_dwait", {30'd0, dwait}, 32'd3);
        chk("rst_iwait", {30'd0, iwait}, 32'd0);

        // Contention: core0 first after reset, then strict alternation every 2 cycles.
        @(posedge CLK); #1;
        RST = 0; n = cyc;
        push(0, 1, 32'h40 ^ KEY, n + 1);
        push(1, 1, 32'h80 ^ KEY, n + 3);
        push(0, 1, 32'h40 ^ KEY, n + 5);
        push(1, 1, 32'h80 ^ KEY, n + 7);
        wait_empty(40);
        @(posedge CLK); #1;
        dREN = 2'b00;

        // Data beats instruction within core0.
        @(posedge CLK); #1;
        n = cyc;
        iREN[0] = 1; iaddr[0] = 32'h700; dREN[0] = 1; daddr[0] = 32'h800;
        push(0, 1, 32'h800 ^ KEY, n + 1);
        push(0, 0, 32'h700 ^ KEY, n + 3);
        while (sbq.size() > 1 && cyc < n + 20) begin @(negedge CLK); #1; end
        @(posedge CLK); #1;
        dREN[0] = 0;
        wait_empty(20);
        @(posedge CLK); #1;
        iREN[0] = 0;

        // Single read with two BUSY cycles: completes in the 4th cycle.
        busy = 2; ovr_en = 1; ovr = 32'hDEAD_BEEF;
        req(0, K_LD, 32'h100, 0, 32'hDEAD_BEEF, 3);
        ovr_en = 0;

        // ERROR finishes the transaction with no retry.
        busy = 1; err = 1;
        req(1, K_LD, 32'h900, 0, 32'h900 ^ KEY, 2);
        err = 0; busy = 0;

        // Instruction fetch on core1.
        req(1, K_I, 32'hA04, 0, 32'hA04 ^ KEY, 1);

        // LL then SC succeeds, writes the store data, drops the link.
        req(0, K_LL, 32'h200, 0, 32'h200 ^ KEY, 1);
        chk("ll_link", {30'd0, link_valid}, 32'd1);
        req(0, K_SC, 32'h200, 32'd7, 32'd1, 1);
        chk("sc_store", last_wr, 32'd7);
        chk("sc_link", {30'd0, link_valid}, 32'd0);

        // Core1 store into the reserved word kills core0's link, so SC fails fast.
        req(0, K_LL, 32'h200, 0, 32'h200 ^ KEY, 1);
        req(1, K_SW, 32'h202, 32'd9, 32'd0, 1);
        chk("sw_link", {30'd0, link_valid}, 32'd0);
        w0 = wen_cycles;
        req(0, K_SC, 32'h200, 32'd5, 32'd0, 1);
        chk("scfail_nowen", 32'(wen_cycles), 32'(w0));

        // SC with no reservation at all.
        w0 = wen_cycles;
        req(1, K_SC, 32'h300, 32'd3, 32'd0, 1);
        chk("sc_nolink_wen", 32'(wen_cycles), 32'(w0));

        // Byte offset is ignored in the reservation compare.
        req(1, K_LL, 32'h400, 0, 32'h400 ^ KEY, 1);
        chk("ll1_link", {30'd0, link_valid}, 32'd2);
        req(1, K_SC, 32'h403, 32'd11, 32'd1, 1);
        chk("sc_off_store", last_wr, 32'd11);

        // Reset in the middle of SERVE abandons the access without completion.
        req(0, K_LL, 32'h600, 0, 32'h600 ^ KEY, 1);
        busy = 5;
        dREN[0] = 1; daddr[0] = 32'h500;
        repeat (3) @(posedge CLK);
        #1;
        chk("pre_rst_ramREN", {31'd0, ramREN}, 32'd1);
        RST = 1;
        @(posedge CLK); #1;
        RST = 0;
        @(negedge CLK);
        chk("midrst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("midrst_dwait", {31'd0, dwait[0]}, 32'd1);
        chk("midrst_link", {30'd0, link_valid}, 32'd0);
        busy = 0;
        push(0, 1, 32'h500 ^ KEY, cyc + 1);
        wait_empty(20);
        @(posedge CLK); #1;
        dREN[0] = 0;

        repeat (3) @(posedge CLK);
        #1;
        chk("final_q_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dual_core_mem_arbiter.md
# dual_core_mem_arbiter

Shares the single RAM port between the instruction and data request ports of two cores. It arbitrates round-robin between cores, with data requests ahead of instruction requests within a core. It sequences each RAM transaction and implements the LL/SC reservation (link register) semantics that back the control unit's `datomic` signal. It sits between the two cores' cache-side request ports and the memory controller.

## Interface
- `WORD_W`, 32: data/address width. Core count is fixed at 2; port index 0/1 selects the core.
- `CLK` in 1: the only clock; everything is on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `iREN[c]` in 1 per core: instruction read request.
- `iaddr[c]` in WORD_W per core: instruction address.
- `iwait[c]` out 1 per core: instruction request not yet complete.
- `iload[c]` out WORD_W per core: instruction data, valid while `iwait` is low after a request.
- `dREN[c]`, `dWEN[c]` in 1 per core: data read or write request. They are never both high.
- `datomic[c]` in 1 per core: with `dREN` the request is LL; with `dWEN` it is SC.
- `daddr[c]`, `dstore[c]` in WORD_W per core: data address and store data.
- `dwait[c]` out 1 per core: data request not yet complete.
- `dload[c]` out WORD_W per core: load data, or the SC result.
- `ramREN`, `ramWEN` out 1: RAM read or write strobe.
- `ramaddr`, `ramstore` out WORD_W: RAM address and write data.
- `ramload` in WORD_W: RAM read data.
- `ramstate` in 2: RAM status. FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- `link_valid` out 2: per-core reservation valid flags, for debug.

## Operation
- FSM states: IDLE, SERVE, SCFAIL.
- **IDLE: candidate order**
  - The core not granted last is considered first; the other core second.
  - Within a core, the data request (`dREN|dWEN`) beats `iREN`.
- **IDLE: normal grant**
  - Latch the core id, port (I/D), op, address and store data into the grant registers.
  - Go to SERVE.
- **IDLE: SC that fails the check**
  - An SC fails when `link_valid[c]`=0 or `linkaddr[c][31:2]` != `daddr[c][31:2]`.
  - Go to SCFAIL without granting the RAM.
- **SERVE**
  - Drive `ramREN` or `ramWEN`, `ramaddr` and `ramstore` from the grant registers.
  - Stay while `ramstate` is FREE or BUSY.
  - On ACCESS or ERROR the transaction completes. ERROR is not retried. Go to IDLE and flip the round-robin pointer to the granted core.
- **SCFAIL**
  - For one cycle `dwait[c]`=0 and `dload[c]`=0.
  - Clear `link_valid[c]`.
  - Go to IDLE. The pointer is not flipped.
- **Completion effects**
  - Read: `iload`/`dload` of the granted core = `ramload` in the completion cycle.
  - LL: set `link_valid[c]`=1 and `linkaddr[c]`=`daddr`.
  - Any completed write (SW or a successful SC): clear every core's link whose `linkaddr[31:2]` equals the write address `[31:2]`, including the writer's own.
  - Successful SC: `dload[c]`=1.
- **Wait signals**
  - `iwait[c]` = `iREN[c]` and not (this is the completion cycle for core c's I port).
  - `dwait[c]` is defined the same way for the D port, where SCFAIL also counts as a completion.
- **Outside completion**
  - `iload`/`dload` = 0.
  - RAM strobes are low in IDLE and SCFAIL.

## Timing
- **Reset** (synchronous; the same effect when asserted mid-transaction):
  - State = IDLE, all RAM outputs = 0, `link_valid` = 00, `linkaddr` = 0.
  - The pointer is set so that core 0 is considered first.
  - Any in-flight transaction is abandoned; no completion is signalled.
- **Latency**
  - Grant decision at edge k; RAM strobes visible from cycle k+1.
  - Completion in the first SERVE cycle with ACCESS/ERROR, so minimum 2 cycles from request to `wait` low.
  - A failed SC completes in 2 cycles (IDLE, then SCFAIL).
- **Handshake**
  - `wait` low lasts exactly one cycle per transaction.
  - After each completion there is one IDLE cycle before the next grant. This gives the core a cycle to retire or change its request.
  - A request that drops before completion while in SERVE still finishes its RAM access, but no completion is signalled.
- **Simultaneous events**
  - Both cores requesting: the round-robin pointer decides.
  - A link set (LL completion) and a clear cannot happen in the same cycle, because transactions are serialised.
- Address compare is on the word address `[31:2]`; byte offset is ignored.

## Test plan
- **Reset behaviour.** Reset asserted mid-SERVE → next cycle RAM strobes 0, `dwait` stays high while the request is held, `link_valid`=00.
- **Single read.** Core0 `dREN`, `daddr`=0x100, RAM gives ACCESS after 2 BUSY cycles with `ramload`=0xDEADBEEF → `dwait[0]` low exactly in cycle 4, `dload[0]`=0xDEADBEEF.
- **Contention.** Both cores hold `dREN` from reset, RAM always ACCESS → grants alternate core0, core1, core0. Each core completes every 4 cycles.
- **Data over instruction.** Core0 `iREN`+`dREN` together → the D port is served first, then I.
- **LL/SC success and interference.**
  - Core0 LL 0x200, then SC 0x200 `dstore`=7 → `ramWEN` with 7, `dload[0]`=1, `link_valid[0]`=0.
  - Repeat with a core1 SW to 0x202 between the LL and the SC → SC fails: no `ramWEN`, `dload[0]`=0, 2-cycle latency.
- **SC with no link.** SC from core1 with no prior LL → fails via SCFAIL; `ramWEN` is never asserted.
